// File: rtl/ahb_pkg.sv
// Shared AHB definitions: HTRANS/HRESP encodings and the arbiter state type.
// No ports; imported by the arbiter and its round-robin picker.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_PARK = 2'd0,
        ST_OWN  = 2'd1,
        ST_LOCK = 2'd2
    } arb_state_e;

endpackage

// File: rtl/ahb_rr_pick.sv
// Combinational round-robin picker: rotate, priority-encode, rotate back.
// Ports: req_i (requests), last_i (last owner), onehot_o/idx_o (winner), valid_o.
module ahb_rr_pick
    import ahb_pkg::*;
#(
    parameter int N = 3,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] last_i,
    output logic [N-1:0] onehot_o,
    output logic [W-1:0] idx_o,
    output logic         valid_o
);

    logic [N-1:0] rot;

    always_comb begin
        rot      = '0;
        onehot_o = '0;
        idx_o    = '0;
        valid_o  = 1'b0;
        // rot[0] is the master right after the last owner, so the
        // last owner itself lands in the lowest-priority slot.
        for (int i = 0; i < N; i++) begin
            rot[i] = req_i[(i + int'(last_i) + 1) % N];
        end
        // Walk downwards so the lowest set rotated bit wins.
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                valid_o = 1'b1;
                idx_o   = W'((i + int'(last_i) + 1) % N);
            end
        end
        if (valid_o) begin
            onehot_o[idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/ahb_arbiter.sv
// Round-robin AHB arbiter with burst protection, locked transfers and parking.
// Ports: HCLK/HRESET, HBUSREQ/HLOCK/HTRANS/HREADY/HRESP in; HGRANT/HMASTER/HMASTER_D/HMASTLOCK out.
module ahb_arbiter
    import ahb_pkg::*;
#(
    parameter int N_MASTERS      = 3,
    parameter int DEFAULT_MASTER = 0,
    localparam int MW = $clog2(N_MASTERS)
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic [N_MASTERS-1:0] HBUSREQ,
    input  logic [N_MASTERS-1:0] HLOCK,
    input  logic [1:0]           HTRANS,
    input  logic                 HREADY,
    input  logic                 HRESP,
    output logic [N_MASTERS-1:0] HGRANT,
    output logic [MW-1:0]        HMASTER,
    output logic [MW-1:0]        HMASTER_D,
    output logic                 HMASTLOCK
);

    localparam logic [N_MASTERS-1:0] DEF_GRANT =
        {{(N_MASTERS-1){1'b0}}, 1'b1} << DEFAULT_MASTER;
    localparam logic [MW-1:0] DEF_IDX = MW'(DEFAULT_MASTER);

    arb_state_e           state_q, state_d;
    logic [N_MASTERS-1:0] grant_q, grant_d;
    logic [MW-1:0]        master_q, master_d;
    logic [MW-1:0]        mdata_q, mdata_d;

    logic [N_MASTERS-1:0] pick_onehot;
    logic [MW-1:0]        pick_idx;
    logic                 pick_valid;
    logic                 addr_hop;
    logic                 lock_hold;
    logic                 hop;
    logic                 win_lock;

    ahb_rr_pick #(
        .N(N_MASTERS)
    ) u_pick (
        .req_i   (HBUSREQ),
        .last_i  (master_q),
        .onehot_o(pick_onehot),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    assign addr_hop  = (HTRANS == HTRANS_IDLE) ||
                       (HTRANS == HTRANS_NONSEQ);
    assign lock_hold = (state_q == ST_LOCK) && HLOCK[master_q];
    // An ERROR response aborts the burst, so it re-arbitrates even when locked.
    assign hop       = HREADY &&
                       ((addr_hop && !lock_hold) || (HRESP == HRESP_ERROR));
    // Masking with HBUSREQ keeps a stray HLOCK from a non-requester out.
    assign win_lock  = |(pick_onehot & HBUSREQ & HLOCK);

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q  <= ST_PARK;
            grant_q  <= DEF_GRANT;
            master_q <= DEF_IDX;
            mdata_q  <= DEF_IDX;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            master_q <= master_d;
            mdata_q  <= mdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        master_d = master_q;
        mdata_d  = mdata_q;
        if (HREADY) begin
            mdata_d = master_q;
        end
        unique case (1'b1)
            !HREADY: begin
            end
            HREADY && !hop: begin
            end
            hop && pick_valid: begin
                grant_d  = pick_onehot;
                master_d = pick_idx;
                state_d  = win_lock ? ST_LOCK : ST_OWN;
            end
            hop && !pick_valid: begin
                grant_d  = DEF_GRANT;
                master_d = DEF_IDX;
                state_d  = ST_PARK;
            end
            default: begin
            end
        endcase
    end

    assign HGRANT    = grant_q;
    assign HMASTER   = master_q;
    assign HMASTER_D = mdata_q;
    assign HMASTLOCK = (state_q == ST_LOCK);

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed vector bench for ahb_arbiter with three masters parked on master 0.
// Each row drives one cycle and lists the outputs expected after that edge.
module tb_ahb_arbiter;

    localparam logic [1:0] IDL = 2'b00;
    localparam logic [1:0] NSQ = 2'b10;
    localparam logic [1:0] SEQ = 2'b11;

    typedef struct {
        logic       rst;
        logic [2:0] req;
        logic [2:0] lk;
        logic [1:0] tr;
        logic       rdy;
        logic       resp;
        logic [2:0] g;
        logic [1:0] m;
        logic [1:0] md;
        logic       ml;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] busreq;
    logic [2:0] lock;
    logic [1:0] trans;
    logic       ready;
    logic       resp;
    logic [2:0] grant;
    logic [1:0] master;
    logic [1:0] master_d;
    logic       mastlock;

    int n_cmp = 0;
    int n_err = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    ahb_arbiter #(
        .N_MASTERS(3),
        .DEFAULT_MASTER(0)
    ) dut (
        .HCLK     (clk),
        .HRESET   (rst),
        .HBUSREQ  (busreq),
        .HLOCK    (lock),
        .HTRANS   (trans),
        .HREADY   (ready),
        .HRESP    (resp),
        .HGRANT   (grant),
        .HMASTER  (master),
        .HMASTER_D(master_d),
        .HMASTLOCK(mastlock)
    );

    function automatic vec_t mk(
        input logic r, input logic [2:0] rq, input logic [2:0] lk,
        input logic [1:0] tr, input logic rd, input logic rs,
        input logic [2:0] g, input logic [1:0] m,
        input logic [1:0] md, input logic ml);
        vec_t v;
        v.rst = r; v.req = rq; v.lk = lk; v.tr = tr;
        v.rdy = rd; v.resp = rs; v.g = g; v.m = m;
        v.md = md; v.ml = ml;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        rst = v.rst; busreq = v.req; lock = v.lk;
        trans = v.tr; ready = v.rdy; resp = v.resp;
    endtask

    task automatic check(input string name, input int row,
                         input logic [2:0] g, input logic [1:0] m,
                         input logic [1:0] md, input logic ml);
        n_cmp++;
        if (grant !== g || master !== m ||
            master_d !== md || mastlock !== ml) begin
            n_err++;
            $display("FAIL %s[%0d]: got g=%b m=%0d md=%0d ml=%b, want g=%b m=%0d md=%0d ml=%b",
                     name, row, grant, master, master_d, mastlock,
                     g, m, md, ml);
        end
    endtask

    task automatic step(input string name, input int row, input vec_t v);
        drive(v);
        @(posedge clk);
        #1;
        check(name, row, v.g, v.m, v.md, v.ml);
    endtask

    initial begin
        // reset and idle park
        vecs.push_back(mk(1, 3'b000, 3'b000, IDL, 1, 0, 3'b001, 0, 0, 0));
        vecs.push_back(mk(1, 3'b000, 3'b000, IDL, 1, 0, 3'b001, 0, 0, 0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0, 3'b000, 3'b000, IDL, 1, 0, 3'b001, 0, 0, 0));
        // round robin with all requesting
        vecs.push_back(mk(0, 3'b111, 3'b000, NSQ, 1, 0, 3'b010, 1, 0, 0));
        vecs.push_back(mk(0, 3'b111, 3'b000, NSQ, 1, 0, 3'b100, 2, 1, 0));
        vecs.push_back(mk(0, 3'b111, 3'b000, NSQ, 1, 0, 3'b001, 0, 2, 0));
        vecs.push_back(mk(0, 3'b111, 3'b000, NSQ, 1, 0, 3'b010, 1, 0, 0));
        vecs.push_back(mk(0, 3'b111, 3'b000, NSQ, 1, 0, 3'b100, 2, 1, 0));
        // master 1 takes the bus, then burst protection
        vecs.push_back(mk(0, 3'b010, 3'b000, NSQ, 1, 0, 3'b010, 1, 2, 0));
        vecs.push_back(mk(0, 3'b101, 3'b000, SEQ, 1, 0, 3'b010, 1, 1, 0));
        vecs.push_back(mk(0, 3'b101, 3'b000, SEQ, 1, 0, 3'b010, 1, 1, 0));
        vecs.push_back(mk(0, 3'b101, 3'b000, SEQ, 1, 0, 3'b010, 1, 1, 0));
        vecs.push_back(mk(0, 3'b101, 3'b000, IDL, 1, 0, 3'b100, 2, 1, 0));
        // wait states at a handover
        vecs.push_back(mk(0, 3'b001, 3'b000, NSQ, 1, 0, 3'b001, 0, 2, 0));
        vecs.push_back(mk(0, 3'b100, 3'b000, NSQ, 0, 0, 3'b001, 0, 2, 0));
        vecs.push_back(mk(0, 3'b100, 3'b000, NSQ, 0, 0, 3'b001, 0, 2, 0));
        vecs.push_back(mk(0, 3'b100, 3'b000, NSQ, 0, 0, 3'b001, 0, 2, 0));
        vecs.push_back(mk(0, 3'b100, 3'b000, NSQ, 1, 0, 3'b100, 2, 0, 0));
        vecs.push_back(mk(0, 3'b100, 3'b000, NSQ, 1, 0, 3'b100, 2, 2, 0));
        // locked sequence, then release
        vecs.push_back(mk(0, 3'b100, 3'b100, NSQ, 1, 0, 3'b100, 2, 2, 1));
        vecs.push_back(mk(0, 3'b111, 3'b100, NSQ, 1, 0, 3'b100, 2, 2, 1));
        vecs.push_back(mk(0, 3'b111, 3'b100, NSQ, 1, 0, 3'b100, 2, 2, 1));
        vecs.push_back(mk(0, 3'b011, 3'b000, NSQ, 1, 0, 3'b001, 0, 2, 0));
        // ERROR breaks a lock
        vecs.push_back(mk(0, 3'b100, 3'b100, NSQ, 1, 0, 3'b100, 2, 0, 1));
        vecs.push_back(mk(0, 3'b111, 3'b100, SEQ, 1, 1, 3'b001, 0, 2, 0));
        // unknown HLOCK on non-requesters
        vecs.push_back(mk(0, 3'b010, 3'bx0x, NSQ, 1, 0, 3'b010, 1, 0, 0));
        // reset in the middle of a locked burst with HREADY low
        vecs.push_back(mk(0, 3'b100, 3'b100, NSQ, 1, 0, 3'b100, 2, 1, 1));
        vecs.push_back(mk(1, 3'b100, 3'b100, SEQ, 0, 0, 3'b001, 0, 0, 0));
        vecs.push_back(mk(0, 3'b000, 3'b000, IDL, 1, 0, 3'b001, 0, 0, 0));
        // back to park after a lone owner drops its request
        vecs.push_back(mk(0, 3'b010, 3'b000, NSQ, 1, 0, 3'b010, 1, 0, 0));
        vecs.push_back(mk(0, 3'b000, 3'b000, IDL, 1, 0, 3'b001, 0, 1, 0));
        vecs.push_back(mk(0, 3'b000, 3'b000, IDL, 1, 0, 3'b001, 0, 0, 0));

        drive(vecs[0]);
        for (int i = 0; i < vecs.size(); i++) begin
            step("vec", i, vecs[i]);
        end

        // long wait state before a grant, then a freeze with HMASTER_D stale
        for (int i = 0; i < 4; i++)
            step("wait_grant", i,
                 mk(0, 3'b010, 3'b000, NSQ, 0, 0, 3'b001, 0, 0, 0));
        step("wait_grant", 4,
             mk(0, 3'b010, 3'b000, NSQ, 1, 0, 3'b010, 1, 0, 0));
        for (int i = 0; i < 2; i++)
            step("wait_md", i,
                 mk(0, 3'b000, 3'b000, IDL, 0, 0, 3'b010, 1, 0, 0));
        step("wait_md", 2,
             mk(0, 3'b000, 3'b000, IDL, 1, 0, 3'b001, 0, 1, 0));
        step("wait_md", 3,
             mk(0, 3'b000, 3'b000, IDL, 1, 0, 3'b001, 0, 0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ahb_arbiter.md
# ahb_arbiter

Round-robin bus arbiter for a multi-master AHB system: it chooses which master owns the shared address/control bus. It drives the master-select lines that steer the master-side address and write-data multiplexing. It also provides a data-phase owner index, one HREADY beat behind, for routing HRDATA/HRESP back to the correct master. It handles locked sequences and never re-arbitrates inside a burst.

## Interface
- N_MASTERS, 3: number of requesting masters (2..8).
- DEFAULT_MASTER, 0: master parked on the bus when nobody requests.
- HCLK  in  1  bus clock; all state changes on rising edge.
- HRESET  in  1  synchronous, active-high reset.
- HBUSREQ  in  N_MASTERS  per-master bus request.
- HLOCK  in  N_MASTERS  per-master lock request, qualified by HBUSREQ.
- HTRANS  in  2  transfer type of the current address-phase owner (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11).
- HREADY  in  1  bus ready (the slave-mux HREADYOUT).
- HRESP  in  1  bus response, 1 = ERROR.
- HGRANT  out  N_MASTERS  one-hot grant; the address-phase owner.
- HMASTER  out  $clog2(N_MASTERS)  index of HGRANT.
- HMASTER_D  out  $clog2(N_MASTERS)  data-phase owner index.
- HMASTLOCK  out  1  current address-phase transfer is locked.

## Operation
- Handover point (HOP): HREADY=1 and HTRANS ∈ {IDLE, NONSEQ} and not (HMASTLOCK=1 and HLOCK[HMASTER]=1).
- ERROR override: HREADY=1 with HRESP=1 is also a HOP, even mid-burst or locked. The burst is treated as aborted.
- FSM states:
  - PARK: DEFAULT_MASTER granted, no active request.
  - OWN: a requester is granted, unlocked.
  - LOCK: a requester is granted with HMASTLOCK=1.
- At each HOP:
  - Round-robin search of HBUSREQ, starting at HMASTER+1 mod N_MASTERS and wrapping. The current owner has the lowest priority.
  - If a requester is found: grant it. Go to LOCK if HLOCK[winner]=1, else OWN.
  - If no requester is found: grant DEFAULT_MASTER and go to PARK.
- HMASTLOCK <= HBUSREQ[winner] & HLOCK[winner], updated only at a HOP.
- Owner drops HBUSREQ mid-burst: the grant is held until the next HOP.
- In LOCK, a HOP with HLOCK[owner]=0 behaves as in OWN.
- HREADY=0: HGRANT, HMASTER, HMASTER_D, HMASTLOCK and the state are all frozen.
- HMASTER_D <= HMASTER on every cycle with HREADY=1, whether or not a HOP occurs.
- HBUSREQ bits at or above N_MASTERS do not exist. An X on a non-requesting master's HLOCK is ignored.

## Timing
- Reset values:
  - HGRANT = 1<<DEFAULT_MASTER; HMASTER = DEFAULT_MASTER; HMASTER_D = DEFAULT_MASTER.
  - HMASTLOCK = 0; state = PARK.
- Grant latency: a request sampled at a HOP edge is granted in the next cycle. HGRANT/HMASTER/HMASTLOCK are registered, with no combinational path from the inputs.
- HMASTER_D follows HMASTER after exactly one HREADY=1 beat. Wait states stretch this.
- HRESET asserted mid-transfer overrides everything on that edge, regardless of HREADY. The bus restarts parked.
- Simultaneous requests with the owner re-requesting: the next master in round-robin order wins. A single requester keeps the bus across consecutive HOPs.

## Structure
- Shared package ahb_pkg:
  - HTRANS encodings: HTRANS_IDLE, HTRANS_BUSY, HTRANS_NONSEQ, HTRANS_SEQ.
  - HRESP_OKAY and HRESP_ERROR.
  - Arbiter state enum {PARK, OWN, LOCK}.
- Sub-module ahb_rr_pick, combinational:
  - Inputs: request vector and last-owner index.
  - Outputs: one-hot winner, winner index, valid.
  - Implemented as rotate, priority-encode, rotate back.
- ahb_arbiter holds the FSM, the grant registers and the HMASTER_D pipeline.

## Test plan
- Reset, then idle:
  - HBUSREQ=000 for 5 cycles gives HGRANT=001, HMASTER=0, state PARK.
  - Assert HRESET mid-burst while owner=2: next cycle gives HGRANT=001 and HMASTLOCK=0.
- Round-robin fairness: HBUSREQ=111, HTRANS=NONSEQ, HREADY=1 every cycle gives HMASTER sequence 1,2,0,1,2… with HMASTER_D lagging by one cycle.
- Burst protection: master 1 owns, HTRANS=NONSEQ then SEQ×3, HBUSREQ=101. The grant stays on 1 through the SEQ beats and moves to 2 only after the beat with HTRANS=IDLE/NONSEQ.
- Wait states: HREADY=0 for 3 cycles at a HOP with HBUSREQ=100. The outputs stay frozen; HGRANT=100 appears the cycle after HREADY returns to 1, and HMASTER_D updates one beat later.
- Locked sequence:
  - Master 2 with HLOCK=1 gives HMASTLOCK=1. Master 2 keeps the bus across NONSEQ beats while HBUSREQ=111.
  - Release HLOCK[2] and HBUSREQ[2]: master 0 is granted at the next HOP.
  - An ERROR response (HRESP=1, HREADY=1) during the lock forces re-arbitration to master 0.
